// File: rtl/avg_line_fifo.sv
// avg_line_fifo
//   First-word-fall-through queue of line segments between the AVG vector
//   core (writer) and the line rasteriser / DAC back end (reader).
//   Each record is {start_x, start_y, end_x, end_y, intensity}.
//
// Ports
//   clk_in, rst       clock, synchronous active-high reset
//   flush             frame-start discard: empties the queue, clears error stats
//   wr_in, wr_*       write strobe (edge or level qualified) and segment fields
//   rd_ready          consumer takes the head entry this cycle
//   rd_valid, rd_*    head entry (combinational from registered storage)
//   count             occupancy, 0..DEPTH
//   full, almost_full, empty   occupancy status
//   overflow          sticky: a push was dropped since reset/flush
//   drop_count        number of dropped pushes, saturating at 16'hFFFF
module avg_line_fifo #(
  parameter int COORD_W   = 13,
  parameter int INT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int EDGE_WR   = 1,
  parameter int AFULL_LVL = 14
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_in,
  input  logic [COORD_W-1:0]       wr_start_x,
  input  logic [COORD_W-1:0]       wr_start_y,
  input  logic [COORD_W-1:0]       wr_end_x,
  input  logic [COORD_W-1:0]       wr_end_y,
  input  logic [INT_W-1:0]         wr_intensity,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [COORD_W-1:0]       rd_start_x,
  output logic [COORD_W-1:0]       rd_start_y,
  output logic [COORD_W-1:0]       rd_end_x,
  output logic [COORD_W-1:0]       rd_end_y,
  output logic [INT_W-1:0]         rd_intensity,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 4 * COORD_W + INT_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] rd_rec;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic             push_req;
  logic             pop;
  logic             push;
  logic             drop;

  assign wr_rec = {wr_start_x, wr_start_y, wr_end_x, wr_end_y, wr_intensity};

  // Edge mode pushes once per rising edge of wr_in; wr_q keeps tracking
  // wr_in through flush cycles so a strobe held across a flush is not
  // mistaken for a fresh edge afterwards.
  always_comb begin
    if (EDGE_WR != 0) push_req = wr_in && !wr_q;
    else              push_req = wr_in;
  end

  assign empty       = (cnt == '0);
  assign full        = (cnt == DEPTH_C);
  assign almost_full = (cnt >= AFULL_C);
  assign rd_valid    = !empty;
  assign count       = cnt;

  // A pop frees a slot in the same cycle, so a push at full still lands.
  assign pop  = rd_valid && rd_ready;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  // Control: pointers, occupancy, edge register, error stats
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      wr_q       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_q <= wr_in;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        cnt        <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
        if (drop) begin
          overflow   <= 1'b1;
          drop_count <= sat_inc16(drop_count);
        end
      end
    end
  end

  // Storage: cleared by reset only; flush leaves stale contents behind
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  // Read side: head entry falls through combinationally
  assign rd_rec = mem[rd_ptr];
  assign {rd_start_x, rd_start_y, rd_end_x, rd_end_y, rd_intensity} = rd_rec;

endmodule

// File: tb/tb_avg_line_fifo.sv
module tb_avg_line_fifo;

  localparam int CW    = 13;
  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int RW    = 4 * CW + IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, wr, rdy;
  logic [CW-1:0] sx, sy, ex, ey;
  logic [IW-1:0] it;
  logic r_valid, full, af, empty, ovf;
  logic [CW-1:0] r_sx, r_sy, r_ex, r_ey;
  logic [IW-1:0] r_it;
  logic [4:0] cnt;
  logic [15:0] drops;

  logic lflush, lw, lrdy;
  logic [CW-1:0] ld;
  logic l_valid, l_full, l_af, l_empty, l_ovf;
  logic [CW-1:0] l_sx, l_sy, l_ex, l_ey;
  logic [IW-1:0] l_it;
  logic [4:0] l_cnt;
  logic [15:0] l_drops;

  avg_line_fifo #(.COORD_W(CW), .INT_W(IW), .DEPTH(DEPTH), .EDGE_WR(1), .AFULL_LVL(AFL)) u_edge (
    .clk_in(clk), .rst(rst), .flush(flush), .wr_in(wr),
    .wr_start_x(sx), .wr_start_y(sy), .wr_end_x(ex), .wr_end_y(ey), .wr_intensity(it),
    .rd_ready(rdy), .rd_valid(r_valid),
    .rd_start_x(r_sx), .rd_start_y(r_sy), .rd_end_x(r_ex), .rd_end_y(r_ey), .rd_intensity(r_it),
    .count(cnt), .full(full), .almost_full(af), .empty(empty),
    .overflow(ovf), .drop_count(drops)
  );

  avg_line_fifo #(.COORD_W(CW), .INT_W(IW), .DEPTH(DEPTH), .EDGE_WR(0), .AFULL_LVL(AFL)) u_lvl (
    .clk_in(clk), .rst(rst), .flush(lflush), .wr_in(lw),
    .wr_start_x(ld), .wr_start_y(ld), .wr_end_x(ld), .wr_end_y(ld), .wr_intensity(ld[IW-1:0]),
    .rd_ready(lrdy), .rd_valid(l_valid),
    .rd_start_x(l_sx), .rd_start_y(l_sy), .rd_end_x(l_ex), .rd_end_y(l_ey), .rd_intensity(l_it),
    .count(l_cnt), .full(l_full), .almost_full(l_af), .empty(l_empty),
    .overflow(l_ovf), .drop_count(l_drops)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the edge-mode queue: a plain FIFO of records
  logic [RW-1:0] mq[$];
  logic          m_prev;
  logic          m_ovf;
  logic [15:0]   m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic preq, pop;
    if (rst) begin
      mq.delete();
      m_prev  = 1'b0;
      m_ovf   = 1'b0;
      m_drops = '0;
    end else begin
      preq   = wr && !m_prev;
      m_prev = wr;
      if (flush) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = '0;
      end else begin
        pop = (mq.size() != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (preq) begin
          if (mq.size() < DEPTH) mq.push_back({sx, sy, ex, ey, it});
          else begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("count", 64'(cnt), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("almost_full", 64'(af), 64'(mq.size() >= AFL));
    chk("rd_valid", 64'(r_valid), 64'(mq.size() != 0));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("drop_count", 64'(drops), 64'(m_drops));
    if (mq.size() != 0) chk("head", 64'({r_sx, r_sy, r_ex, r_ey, r_it}), 64'(mq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rand_data();
    sx = CW'($urandom); sy = CW'($urandom); ex = CW'($urandom); ey = CW'($urandom);
    it = IW'($urandom);
  endtask

  initial begin
    int mx;
    logic anyfull;
    rst = 1'b1; flush = 1'b0; wr = 1'b0; rdy = 1'b0;
    sx = '0; sy = '0; ex = '0; ey = '0; it = '0;
    lflush = 1'b0; lw = 1'b0; lrdy = 1'b0; ld = '0;
    #1;
    tick(); tick();
    chk("rst_data", 64'({r_sx, r_sy, r_ex, r_ey, r_it}), 64'd0);
    chk("rst_lvl_empty", 64'(l_empty), 64'd1);
    chk("rst_lvl_data", 64'({l_sx, l_it}), 64'd0);
    rst = 1'b0;

    // 1: held strobe yields one entry in edge mode
    sx = 13'h0123; it = 4'd5; wr = 1'b1;
    repeat (5) tick();
    chk("t1_count", 64'(cnt), 64'd1);
    chk("t1_sx", 64'(r_sx), 64'h0123);
    chk("t1_int", 64'(r_it), 64'd5);
    wr = 1'b0; flush = 1'b1; tick(); flush = 1'b0;

    // 2: fill, then three dropped pushes
    for (int i = 0; i < DEPTH; i++) begin
      rand_data(); sx = CW'(i);
      wr = 1'b1; tick(); wr = 1'b0; tick();
    end
    chk("t2_full", 64'(full), 64'd1);
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; tick(); wr = 1'b0; tick();
    end
    chk("t2_ovf", 64'(ovf), 64'd1);
    chk("t2_drops", 64'(drops), 64'd3);

    // 3: push at full with simultaneous pop
    rand_data(); sx = 13'h00AA;
    wr = 1'b1; rdy = 1'b1; tick();
    chk("t3_count", 64'(cnt), 64'd16);
    chk("t3_drops", 64'(drops), 64'd3);
    chk("t3_head", 64'(r_sx), 64'd1);
    wr = 1'b0; rdy = 1'b0; tick();
    for (int k = 0; k < DEPTH; k++) begin
      chk("t3_drain", 64'(r_sx), (k < DEPTH - 1) ? 64'(k + 1) : 64'h00AA);
      rdy = 1'b1; tick();
    end
    rdy = 1'b0;
    chk("t3_empty", 64'(empty), 64'd1);

    // 5: flush with concurrent push and pop while overflow is set
    for (int i = 0; i < 7; i++) begin
      rand_data(); wr = 1'b1; tick(); wr = 1'b0; tick();
    end
    chk("t5_pre_count", 64'(cnt), 64'd7);
    chk("t5_pre_ovf", 64'(ovf), 64'd1);
    rand_data(); flush = 1'b1; wr = 1'b1; rdy = 1'b1; tick();
    flush = 1'b0; rdy = 1'b0;
    chk("t5_count", 64'(cnt), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    chk("t5_drops", 64'(drops), 64'd0);
    tick();
    chk("t5_no_edge_after_flush", 64'(cnt), 64'd0);
    wr = 1'b0; tick();

    // 6: interleaved push/pop wraps the pointers
    mx = 0; anyfull = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rand_data(); sx = CW'(i + 100);
      wr = 1'b1; rdy = 1'b0; tick();
      if (int'(cnt) > mx) mx = int'(cnt);
      anyfull |= full;
      chk("t6_head", 64'(r_sx), 64'(i + 100));
      wr = 1'b0; rdy = 1'b1; tick();
      anyfull |= full;
    end
    rdy = 1'b0;
    chk("t6_max", 64'(mx <= 2), 64'd1);
    chk("t6_nofull", 64'(anyfull), 64'd0);

    // 4: level-qualified strobe on the second instance
    lw = 1'b1; ld = 13'd1; tick();
    chk("t4_c1", 64'(l_cnt), 64'd1); chk("t4_h1", 64'(l_sx), 64'd1);
    ld = 13'd2; tick();
    chk("t4_c2", 64'(l_cnt), 64'd2); chk("t4_h2", 64'(l_sx), 64'd1);
    ld = 13'd3; lrdy = 1'b1; tick();
    chk("t4_c3", 64'(l_cnt), 64'd2); chk("t4_h3", 64'(l_sx), 64'd2);
    ld = 13'd4; tick();
    chk("t4_c4", 64'(l_cnt), 64'd2); chk("t4_h4", 64'(l_sx), 64'd3);
    lw = 1'b0; tick();
    chk("t4_c5", 64'(l_cnt), 64'd1); chk("t4_h5", 64'(l_sx), 64'd4);
    tick();
    chk("t4_empty", 64'(l_empty), 64'd1);
    lrdy = 1'b0;

    // Random traffic: a filling phase, then a draining phase, rare flushes
    for (int i = 0; i < 400; i++) begin
      rand_data();
      wr    = 1'($urandom_range(0, 1));
      rdy   = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end
    flush = 1'b0;

    // Reset in the middle of traffic
    while (cnt < 5'd3) begin
      rand_data(); wr = 1'b1; rdy = 1'b0; tick(); wr = 1'b0; tick();
    end
    rst = 1'b1; wr = 1'b1; rdy = 1'b1; flush = 1'b1; tick();
    chk("midrst_data", 64'({r_sx, r_sy, r_ex, r_ey, r_it}), 64'd0);
    rst = 1'b0; flush = 1'b0; rdy = 1'b0; rand_data(); tick();
    chk("midrst_push", 64'(cnt), 64'd1);
    wr = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
